// File: rtl/serial_sample_receiver.sv
// 8N1 UART receiver that reassembles 4-byte frames into two 16-bit mic samples.
// Optional build macro MARKER_DETECT_EN: frames with sample_1==16'hFFFF pulse `marker` instead of `valid`.
module serial_sample_receiver #(
  parameter int CLKS_PER_BIT = 15,
  parameter int GAP_CLKS     = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] sample_1,
  output logic [15:0] sample_2,
  output logic        valid,
  output logic        frame_err,
  output logic [1:0]  byte_idx
`ifdef MARKER_DETECT_EN
  ,
  output logic        marker
`endif
);

  // state | meaning
  // IDLE  | line idle, waiting for a start edge; gap timer runs mid-frame
  // START | qualifying the start bit at its midpoint
  // DATA  | sampling 8 data bits at mid-bit, LSB first
  // STOP  | checking the stop bit at mid-bit
  // BRK   | bad stop bit seen; waiting for the line to return high
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW = $clog2(GAP_CLKS + 1);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CLKS - 1);

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [15:0]   s1_q, s1_d, s2_q, s2_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [GW-1:0] gap_q, gap_d;
`ifdef MARKER_DETECT_EN
  logic          marker_q, marker_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      gap_q    <= GAP_LOAD;
`ifdef MARKER_DETECT_EN
      marker_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      gap_q    <= gap_d;
`ifdef MARKER_DETECT_EN
      marker_q <= marker_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    gap_d    = GAP_LOAD;
`ifdef MARKER_DETECT_EN
    marker_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // Timeout is resolved before the start edge so a coincident byte lands as byte0.
        if (idx_q != 2'd0) begin
          if (gap_q == '0) begin
            err_d = 1'b1;
            idx_d = 2'd0;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
        if (!rx_sync_q) state_d = START;
      end

      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            // Return to IDLE at mid stop bit so a zero-gap next start edge is caught.
            state_d = IDLE;
            idx_d   = idx_q + 2'd1;
            case (idx_q)
              2'd0: b0_d = shift_q;
              2'd1: b1_d = shift_q;
              2'd2: b2_d = shift_q;
              default: begin
`ifdef MARKER_DETECT_EN
                if ({b0_q, b1_q} == 16'hFFFF) begin
                  s2_d     = {b2_q, shift_q};
                  marker_d = 1'b1;
                end else begin
                  s1_d    = {b0_q, b1_q};
                  s2_d    = {b2_q, shift_q};
                  valid_d = 1'b1;
                end
`else
                s1_d    = {b0_q, b1_q};
                s2_d    = {b2_q, shift_q};
                valid_d = 1'b1;
`endif
              end
            endcase
          end else begin
            err_d   = 1'b1;
            idx_d   = 2'd0;
            state_d = BRK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      BRK: begin
        cnt_d = '0;
        if (rx_sync_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign sample_1  = s1_q;
  assign sample_2  = s2_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign byte_idx  = idx_q;
`ifdef MARKER_DETECT_EN
  assign marker    = marker_q;
`endif

endmodule

// File: tb/tb_serial_sample_receiver.sv
// Directed bench for serial_sample_receiver: frames, glitch, bad stop, gap timeout, mid-byte reset.
module tb_serial_sample_receiver;

  localparam int CPB = 15;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [15:0] sample_1;
  logic [15:0] sample_2;
  logic        valid;
  logic        frame_err;
  logic [1:0]  byte_idx;
`ifdef MARKER_DETECT_EN
  logic        marker;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int marker_cnt = 0;

  serial_sample_receiver #(.CLKS_PER_BIT(CPB), .GAP_CLKS(300)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .sample_1  (sample_1),
    .sample_2  (sample_2),
    .valid     (valid),
    .frame_err (frame_err),
    .byte_idx  (byte_idx)
`ifdef MARKER_DETECT_EN
    ,
    .marker    (marker)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) valid_cnt++;
      if (frame_err) err_cnt++;
      if (valid && frame_err) both_cnt++;
`ifdef MARKER_DETECT_EN
      if (marker) marker_cnt++;
`endif
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
    send_byte(d, 1'b1);
  endtask

  int v0, e0, m0;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_s1", 32'(sample_1), 32'h0);
    check_eq("rst_s2", 32'(sample_2), 32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_err", 32'(frame_err), 32'h0);
    check_eq("rst_idx", 32'(byte_idx), 32'h0);
    rst = 1'b0;
    idle(10);

    // Back-to-back frame.
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h12, 8'h34, 8'hAB, 8'hCD);
    idle(10);
    check_eq("f1_s1", 32'(sample_1), 32'h1234);
    check_eq("f1_s2", 32'(sample_2), 32'hABCD);
    check_eq("f1_valid_pulses", 32'(valid_cnt - v0), 32'd1);
    check_eq("f1_err_pulses", 32'(err_cnt - e0), 32'd0);
    check_eq("f1_idx", 32'(byte_idx), 32'h0);

    // Short low glitch on idle line.
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(30);
    check_eq("gl_idx", 32'(byte_idx), 32'h0);
    check_eq("gl_valid_pulses", 32'(valid_cnt - v0), 32'd0);
    check_eq("gl_err_pulses", 32'(err_cnt - e0), 32'd0);
    check_eq("gl_s1_hold", 32'(sample_1), 32'h1234);

    // Bad stop bit, then a clean frame.
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h55, 1'b0);
    idle(10);
    check_eq("bs_err_pulses", 32'(err_cnt - e0), 32'd1);
    check_eq("bs_idx", 32'(byte_idx), 32'h0);
    check_eq("bs_valid_pulses", 32'(valid_cnt - v0), 32'd0);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04);
    idle(10);
    check_eq("bs_f_s1", 32'(sample_1), 32'h0102);
    check_eq("bs_f_s2", 32'(sample_2), 32'h0304);
    check_eq("bs_f_valid_pulses", 32'(valid_cnt - v0), 32'd1);

    // Mid-frame gap timeout.
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h11, 1'b1);
    idle(2);
    check_eq("gap_idx1", 32'(byte_idx), 32'h1);
    send_byte(8'h22, 1'b1);
    idle(2);
    check_eq("gap_idx2", 32'(byte_idx), 32'h2);
    idle(298);
    check_eq("gap_err_pulses", 32'(err_cnt - e0), 32'd1);
    check_eq("gap_idx0", 32'(byte_idx), 32'h0);
    send_frame(8'h33, 8'h44, 8'h55, 8'h66);
    idle(10);
    check_eq("gap_s1", 32'(sample_1), 32'h3344);
    check_eq("gap_s2", 32'(sample_2), 32'h5566);
    check_eq("gap_valid_pulses", 32'(valid_cnt - v0), 32'd1);

    // Reset during bit 4 of byte2.
    send_byte(8'h0A, 1'b1);
    send_byte(8'h0B, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 2) || (i == 3);
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mr_s1", 32'(sample_1), 32'h0);
    check_eq("mr_s2", 32'(sample_2), 32'h0);
    check_eq("mr_idx", 32'(byte_idx), 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(20);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D);
    idle(10);
    check_eq("mr_f_s1", 32'(sample_1), 32'h0A0B);
    check_eq("mr_f_s2", 32'(sample_2), 32'h0C0D);
    check_eq("mr_f_valid_pulses", 32'(valid_cnt - v0), 32'd1);
    check_eq("mr_f_err_pulses", 32'(err_cnt - e0), 32'd0);

    // All-ones first sample.
    v0 = valid_cnt; m0 = marker_cnt;
    send_frame(8'hFF, 8'hFF, 8'h00, 8'h07);
    idle(10);
    check_eq("mk_s2", 32'(sample_2), 32'h0007);
`ifdef MARKER_DETECT_EN
    check_eq("mk_marker_pulses", 32'(marker_cnt - m0), 32'd1);
    check_eq("mk_valid_pulses", 32'(valid_cnt - v0), 32'd0);
    check_eq("mk_s1_hold", 32'(sample_1), 32'h0A0B);
`else
    check_eq("mk_valid_pulses", 32'(valid_cnt - v0), 32'd1);
    check_eq("mk_s1", 32'(sample_1), 32'hFFFF);
`endif

    check_eq("valid_err_overlap", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
